// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network front end: encoder FSM states,
// default widths and the step-counter width helper.
package snn_pkg;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_e;

  localparam int SNN_N_CH   = 32'sd16;
  localparam int SNN_VAL_W  = 32'sd8;
  localparam int SNN_WINDOW = 32'sd256;

  // Step counter only has to reach WINDOW-1, but never shrinks below one bit.
  function automatic int step_width(input int window);
    if (window <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(window);
    end
  endfunction

endpackage

// File: rtl/rate_channel.sv
// One encoder channel: holds the sampled intensity, accumulates it on every
// timestep and emits the accumulator carry as a one-cycle axon pulse.
module rate_channel
  import snn_pkg::*;
#(
  parameter int VAL_W = SNN_VAL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [VAL_W-1:0] val_i,
  output logic             axon_o
);

  logic [VAL_W-1:0] val_q, val_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic             axon_q, axon_d;
  logic [VAL_W:0]   sum_s;

  // Next-state for value, accumulator and carry-to-axon register.
  always_comb begin
    sum_s  = {1'b0, acc_q} + {1'b0, val_q};
    val_d  = val_q;
    acc_d  = acc_q;
    axon_d = 1'b0;
    if (load_i) begin
      val_d = val_i;
    end else begin
      val_d = val_q;
    end
    if (clear_i) begin
      acc_d = '0;
    end else if (tick_i) begin
      acc_d  = sum_s[VAL_W-1:0];
      axon_d = sum_s[VAL_W];
    end else begin
      acc_d = acc_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      val_q  <= '0;
      acc_q  <= '0;
      axon_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      acc_q  <= acc_d;
      axon_q <= axon_d;
    end
  end

  assign axon_o = axon_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: accepts one sample per window and converts each channel's
// intensity into evenly spaced axon pulses over WINDOW tick-paced timesteps.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int N_CH   = SNN_N_CH,
  parameter int VAL_W  = SNN_VAL_W,
  parameter int WINDOW = SNN_WINDOW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_CH*VAL_W-1:0] in_data_i,
  input  logic                  tick_i,
  output logic [N_CH-1:0]       axon_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int STEP_W = step_width(WINDOW);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 32'sd1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(32'sd1);
  localparam logic [0:0] ST_IDLE = 1'(ENC_IDLE);
  localparam logic [0:0] ST_RUN  = 1'(ENC_RUN);

  logic [0:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;
  logic              accept_s;
  logic              run_tick_s;

  // Window FSM and step counter; ticks only count while running.
  always_comb begin
    accept_s   = in_valid_i && (state_q == ST_IDLE);
    run_tick_s = tick_i && (state_q == ST_RUN);
    state_d    = state_q;
    step_d     = step_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          step_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (run_tick_s) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // FSM, step counter and done pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = done_q;

  // A new sample both loads the value and restarts the accumulator.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rate_channel #(
      .VAL_W (VAL_W)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (accept_s),
      .clear_i (accept_s),
      .tick_i  (run_tick_s),
      .val_i   (in_data_i[g*VAL_W +: VAL_W]),
      .axon_o  (axon_o[g])
    );
  end

endmodule
